// File: rtl/voice_tdm_sequencer_pkg.sv
// Shared constants and types for the voice TDM sequencer: slot geometry,
// waveform codes and sample rails.
package voice_tdm_sequencer_pkg;

  localparam int NUM_VOICES = 10;
  localparam int DATA_W     = 24;
  localparam int PHASE_W    = 24;
  localparam int SLOT_W     = 4;

  typedef enum logic [1:0] {
    WAVE_SAW    = 2'd0,
    WAVE_SQUARE = 2'd1,
    WAVE_TRI    = 2'd2,
    WAVE_RSVD   = 2'd3
  } wave_e;

  localparam logic [DATA_W-1:0] SAMPLE_MAX     = 24'h7FFFFF;
  localparam logic [DATA_W-1:0] SAMPLE_MIN     = 24'h800000;
  // Square swings symmetrically, so its low rail is -SAMPLE_MAX, not SAMPLE_MIN.
  localparam logic [DATA_W-1:0] SAMPLE_NEG_MAX = SAMPLE_MIN | 24'h000001;

  typedef struct packed {
    logic               en;
    wave_e              wave;
    logic [PHASE_W-1:0] inc;
  } voice_cfg_t;

  function automatic logic is_last_slot(input logic [SLOT_W-1:0] slot);
    return slot == SLOT_W'(NUM_VOICES - 1);
  endfunction

endpackage

// File: rtl/voice_tdm_sequencer_if.sv
// Frame tick, voice configuration port and TDM sample stream of the sequencer.
interface voice_tdm_sequencer_if;
  import voice_tdm_sequencer_pkg::*;

  logic                  i_frame_tick;
  logic                  i_cfg_we;
  logic [SLOT_W-1:0]     i_cfg_voice;
  logic                  i_cfg_en;
  logic [1:0]            i_cfg_wave;
  logic [PHASE_W-1:0]    i_cfg_inc;
  logic [DATA_W-1:0]     o_sample;
  logic                  o_valid;
  logic [SLOT_W-1:0]     o_slot;
  logic                  o_last;
  logic                  o_busy;
  logic                  o_overrun;

  modport master (
    output i_frame_tick, i_cfg_we, i_cfg_voice, i_cfg_en, i_cfg_wave, i_cfg_inc,
    input  o_sample, o_valid, o_slot, o_last, o_busy, o_overrun
  );

  modport slave (
    input  i_frame_tick, i_cfg_we, i_cfg_voice, i_cfg_en, i_cfg_wave, i_cfg_inc,
    output o_sample, o_valid, o_slot, o_last, o_busy, o_overrun
  );

endinterface

// File: rtl/voice_wavegen.sv
// Combinational waveform shaper: top DATA_W bits of a voice phase plus the
// waveform code give one signed sample; disabled or reserved voices give 0.
module voice_wavegen
  import voice_tdm_sequencer_pkg::*;
(
  input  logic [PHASE_W-1:0] phase,
  input  wave_e              wave,
  input  logic               en,
  output logic [DATA_W-1:0]  sample
);

  localparam int MSB = DATA_W - 1;

  logic [DATA_W-1:0] p;
  logic [DATA_W-2:0] tri_t;

  always_comb begin
    p      = phase[PHASE_W-1 -: DATA_W];
    tri_t  = p[MSB] ? ~p[MSB-1:0] : p[MSB-1:0];
    sample = '0;
    if (en) begin
      case (wave)
        WAVE_SAW:    sample = {~p[MSB], p[MSB-1:0]};
        WAVE_SQUARE: sample = p[MSB] ? SAMPLE_NEG_MAX : SAMPLE_MAX;
        // {t,0} - 2^(DATA_W-1) reduces to flipping the top bit of {t,0}.
        WAVE_TRI:    sample = {~tri_t[DATA_W-2], tri_t[DATA_W-3:0], 1'b0};
        default:     sample = '0;
      endcase
    end
  end

endmodule

// File: rtl/voice_tdm_sequencer.sv
// Walks all voice slots once per frame tick, emitting one registered sample
// per clock and advancing each enabled voice's phase accumulator.
module voice_tdm_sequencer
  import voice_tdm_sequencer_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  voice_tdm_sequencer_if.slave  bus
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]         state_reg, state_next;
  logic [SLOT_W-1:0]  slot_reg, slot_next;
  logic               emit;
  logic [SLOT_W-1:0]  cur_slot;

  voice_cfg_t         cfg_reg   [NUM_VOICES];
  voice_cfg_t         cfg_next  [NUM_VOICES];
  logic [PHASE_W-1:0] phase_reg [NUM_VOICES];
  logic [PHASE_W-1:0] phase_next[NUM_VOICES];
  voice_cfg_t         wr_cfg;

  voice_cfg_t         sel_cfg;
  logic [PHASE_W-1:0] sel_phase;
  logic [DATA_W-1:0]  wave_sample;

  logic [DATA_W-1:0]  sample_reg;
  logic               valid_reg;
  logic [SLOT_W-1:0]  slot_out_reg;
  logic               last_reg;
  logic               busy_reg;
  logic               overrun_reg;

  // Slot 0 is emitted on the tick edge itself so strobes land in T+1..T+N.
  always_comb begin
    state_next = state_reg;
    slot_next  = slot_reg;
    emit       = 1'b0;
    cur_slot   = '0;
    case (state_reg)
      ST_IDLE: begin
        if (bus.i_frame_tick) begin
          emit       = 1'b1;
          state_next = ST_RUN;
          slot_next  = SLOT_W'(1);
        end
      end
      ST_RUN: begin
        emit     = 1'b1;
        cur_slot = slot_reg;
        if (is_last_slot(slot_reg)) begin
          state_next = ST_IDLE;
          slot_next  = '0;
        end else begin
          slot_next = slot_reg + SLOT_W'(1);
        end
      end
      default: begin
        state_next = ST_IDLE;
        slot_next  = '0;
      end
    endcase
  end

  assign wr_cfg = '{en: bus.i_cfg_en, wave: wave_e'(bus.i_cfg_wave), inc: bus.i_cfg_inc};

  for (genvar gi = 0; gi < NUM_VOICES; gi++) begin : g_voice
    logic wr_hit;
    logic adv_hit;
    logic en_rise;

    assign wr_hit  = bus.i_cfg_we && (bus.i_cfg_voice == SLOT_W'(gi));
    assign adv_hit = emit && (cur_slot == SLOT_W'(gi)) && cfg_reg[gi].en;
    assign en_rise = wr_hit && bus.i_cfg_en && !cfg_reg[gi].en;

    assign cfg_next[gi]   = wr_hit ? wr_cfg : cfg_reg[gi];
    // Enabling a voice restarts it from phase 0, even over a same-cycle advance.
    assign phase_next[gi] = en_rise ? '0 :
                            adv_hit ? phase_reg[gi] + cfg_reg[gi].inc :
                                      phase_reg[gi];
  end

  assign sel_cfg   = cfg_reg[cur_slot];
  assign sel_phase = phase_reg[cur_slot];

  voice_wavegen u_wavegen (
    .phase  (sel_phase),
    .wave   (sel_cfg.wave),
    .en     (sel_cfg.en),
    .sample (wave_sample)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      slot_reg     <= '0;
      sample_reg   <= '0;
      valid_reg    <= 1'b0;
      slot_out_reg <= '0;
      last_reg     <= 1'b0;
      busy_reg     <= 1'b0;
      overrun_reg  <= 1'b0;
      for (int v = 0; v < NUM_VOICES; v++) begin
        cfg_reg[v]   <= '0;
        phase_reg[v] <= '0;
      end
    end else begin
      state_reg   <= state_next;
      slot_reg    <= slot_next;
      valid_reg   <= emit;
      busy_reg    <= emit;
      overrun_reg <= bus.i_frame_tick && (state_reg == ST_RUN);
      if (emit) begin
        sample_reg   <= wave_sample;
        slot_out_reg <= cur_slot;
        last_reg     <= is_last_slot(cur_slot);
      end
      for (int v = 0; v < NUM_VOICES; v++) begin
        cfg_reg[v]   <= cfg_next[v];
        phase_reg[v] <= phase_next[v];
      end
    end
  end

  assign bus.o_sample  = sample_reg;
  assign bus.o_valid   = valid_reg;
  assign bus.o_slot    = slot_out_reg;
  assign bus.o_last    = last_reg;
  assign bus.o_busy    = busy_reg;
  assign bus.o_overrun = overrun_reg;

endmodule

// File: tb/tb_voice_tdm_sequencer.sv
// Directed bench for voice_tdm_sequencer: frame timing, waveforms, overrun,
// same-cycle config writes and mid-frame reset against hand-computed values.
module tb_voice_tdm_sequencer;
  import voice_tdm_sequencer_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  voice_tdm_sequencer_if bus();

  voice_tdm_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int samp[NUM_VOICES];

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end else begin
      $display("ok   %s: %0d", tag, obs);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [3:0] v, input logic en, input logic [1:0] wave,
                           input logic [23:0] inc);
    bus.i_cfg_voice = v;
    bus.i_cfg_en    = en;
    bus.i_cfg_wave  = wave;
    bus.i_cfg_inc   = inc;
    bus.i_cfg_we    = 1'b1;
    step();
    bus.i_cfg_we    = 1'b0;
  endtask

  // One full frame; optionally drives a config write during cycle T+wr_k,
  // the cycle in which slot wr_k is being emitted.
  task automatic run_frame(input string name, input int wr_k, input logic [3:0] wv,
                           input logic wen, input logic [1:0] wwave, input logic [23:0] winc);
    bus.i_frame_tick = 1'b1;
    step();
    bus.i_frame_tick = 1'b0;
    for (int k = 0; k < NUM_VOICES; k++) begin
      check($sformatf("%s valid k%0d", name, k), int'(bus.o_valid), 1);
      check($sformatf("%s slot k%0d", name, k), int'(bus.o_slot), k);
      check($sformatf("%s last k%0d", name, k), int'(bus.o_last), (k == NUM_VOICES - 1) ? 1 : 0);
      samp[k] = $signed(bus.o_sample);
      if (k == wr_k - 1) begin
        bus.i_cfg_voice = wv;
        bus.i_cfg_en    = wen;
        bus.i_cfg_wave  = wwave;
        bus.i_cfg_inc   = winc;
        bus.i_cfg_we    = 1'b1;
      end
      if (k == wr_k) bus.i_cfg_we = 1'b0;
      step();
    end
    check($sformatf("%s valid_after", name), int'(bus.o_valid), 0);
    check($sformatf("%s busy_after", name), int'(bus.o_busy), 0);
  endtask

  int exp_saw0[3] = '{-8388608, -7340032, -6291456};
  int exp_sq[4]   = '{8388607, 8388607, -8388607, -8388607};
  int exp_tri[4]  = '{-8388608, 0, 8388606, -2};
  int exp_wrap[3] = '{-8388608, 0, -8388608};
  int exp_wr[3]   = '{-6291456, -4194304, -3145728};
  int cnt;

  initial begin
    bus.i_frame_tick = 1'b0;
    bus.i_cfg_we     = 1'b0;
    bus.i_cfg_voice  = '0;
    bus.i_cfg_en     = 1'b0;
    bus.i_cfg_wave   = '0;
    bus.i_cfg_inc    = '0;
    rst = 1'b1;
    repeat (3) step();

    // Reset state
    check("rst valid", int'(bus.o_valid), 0);
    check("rst sample", int'(bus.o_sample), 0);
    check("rst slot", int'(bus.o_slot), 0);
    check("rst last", int'(bus.o_last), 0);
    check("rst busy", int'(bus.o_busy), 0);
    check("rst overrun", int'(bus.o_overrun), 0);
    rst = 1'b0;
    step();

    // Unconfigured frame: ten zero samples
    run_frame("idle", -1, 4'd0, 1'b0, 2'd0, 24'd0);
    for (int k = 0; k < NUM_VOICES; k++)
      check($sformatf("idle sample s%0d", k), samp[k], 0);

    // Voice 0 saw
    cfg_write(4'd0, 1'b1, WAVE_SAW, 24'h100000);
    for (int f = 0; f < 3; f++) begin
      run_frame($sformatf("saw f%0d", f), -1, 4'd0, 1'b0, 2'd0, 24'd0);
      check($sformatf("saw0 f%0d", f), samp[0], exp_saw0[f]);
    end

    // Square on 3, reserved on 4, triangle on 5
    cfg_write(4'd3, 1'b1, WAVE_SQUARE, 24'h400000);
    cfg_write(4'd4, 1'b1, WAVE_RSVD, 24'h100000);
    cfg_write(4'd5, 1'b1, WAVE_TRI, 24'h400000);
    for (int f = 0; f < 4; f++) begin
      run_frame($sformatf("wav f%0d", f), -1, 4'd0, 1'b0, 2'd0, 24'd0);
      check($sformatf("sq3 f%0d", f), samp[3], exp_sq[f]);
      check($sformatf("rsvd4 f%0d", f), samp[4], 0);
      check($sformatf("tri5 f%0d", f), samp[5], exp_tri[f]);
    end

    // Phase wrap on voice 1
    cfg_write(4'd1, 1'b1, WAVE_SAW, 24'h800000);
    for (int f = 0; f < 3; f++) begin
      run_frame($sformatf("wrap f%0d", f), -1, 4'd0, 1'b0, 2'd0, 24'd0);
      check($sformatf("wrap1 f%0d", f), samp[1], exp_wrap[f]);
    end

    // Tick at T+3 while busy: overrun at T+4, no extra frame
    cnt = 0;
    bus.i_frame_tick = 1'b1;
    for (int c = 1; c <= 25; c++) begin
      step();
      if (c == 1) bus.i_frame_tick = 1'b0;
      if (bus.o_valid) cnt++;
      if (c == 3) bus.i_frame_tick = 1'b1;
      if (c == 4) begin
        bus.i_frame_tick = 1'b0;
        check("ovr pulse T+4", int'(bus.o_overrun), 1);
      end
      if (c == 5) check("ovr clear T+5", int'(bus.o_overrun), 0);
    end
    check("ovr strobe count", cnt, 10);

    // Tick in the cycle the FSM returns to idle: back-to-back frames
    cnt = 0;
    bus.i_frame_tick = 1'b1;
    for (int c = 1; c <= 25; c++) begin
      step();
      if (c == 1) bus.i_frame_tick = 1'b0;
      if (bus.o_valid) cnt++;
      if (c == 10) bus.i_frame_tick = 1'b1;
      if (c == 11) begin
        bus.i_frame_tick = 1'b0;
        check("b2b no overrun", int'(bus.o_overrun), 0);
        check("b2b valid T+11", int'(bus.o_valid), 1);
        check("b2b slot T+11", int'(bus.o_slot), 0);
        check("b2b busy T+11", int'(bus.o_busy), 1);
      end
    end
    check("b2b strobe count", cnt, 20);

    // Write to voice 2 inc in the cycle it is emitted
    cfg_write(4'd2, 1'b1, WAVE_SAW, 24'h200000);
    run_frame("wr A", -1, 4'd0, 1'b0, 2'd0, 24'd0);
    check("wr2 A", samp[2], -8388608);
    run_frame("wr B", 2, 4'd2, 1'b1, WAVE_SAW, 24'h100000);
    check("wr2 B", samp[2], exp_wr[0]);
    for (int f = 1; f < 3; f++) begin
      run_frame($sformatf("wr f%0d", f), -1, 4'd0, 1'b0, 2'd0, 24'd0);
      check($sformatf("wr2 f%0d", f), samp[2], exp_wr[f]);
    end

    // Reset while slot 4 is on the output
    bus.i_frame_tick = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      step();
      if (c == 1) bus.i_frame_tick = 1'b0;
    end
    check("mid slot before rst", int'(bus.o_slot), 4);
    rst = 1'b1;
    #1;
    check("mid rst valid", int'(bus.o_valid), 0);
    check("mid rst sample", int'(bus.o_sample), 0);
    check("mid rst busy", int'(bus.o_busy), 0);
    step();
    rst = 1'b0;
    cnt = 0;
    for (int c = 0; c < 15; c++) begin
      step();
      if (bus.o_valid) cnt++;
    end
    check("post rst strobes", cnt, 0);
    run_frame("post rst", -1, 4'd0, 1'b0, 2'd0, 24'd0);
    for (int k = 0; k < NUM_VOICES; k++)
      check($sformatf("post rst sample s%0d", k), samp[k], 0);
    cfg_write(4'd0, 1'b1, WAVE_SAW, 24'h000000);
    run_frame("re-en", -1, 4'd0, 1'b0, 2'd0, 24'd0);
    check("re-en saw0", samp[0], -8388608);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
